reorder_buffer: RTL and testbench

// - Parametrised circular reorder buffer for the out-of-order RISC-V core.
// - Sits between dispatch (allocation), complete (FU result writeback) and rename (free-pool return).
// - Generalises the fixed 16-row, 2-wide rob_row table to DEPTH rows, W alloc/retire lanes and C completion ports.
// - Adds in-order multi-retire, flush and occupancy status.

---
 rtl/reorder_buffer_pkg.sv | 30 +++
 rtl/reorder_buffer_retire_sel.sv | 30 +++
 rtl/reorder_buffer.sv | 142 ++++++++++++++
 tb/tb_reorder_buffer.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/reorder_buffer_pkg.sv
// Shared ROB types and default sizing for the out-of-order core.
package reorder_buffer_pkg;

  localparam int ROB_DEPTH  = 16;
  localparam int ROB_W      = 2;
  localparam int CDB_PORTS  = 3;
  localparam int ROB_PREG_W = 6;
  localparam int ROB_DATA_W = 32;
  localparam int ROB_IDX_W  = $clog2(ROB_DEPTH);

  typedef enum logic {
    INSTR_REG   = 1'b0,
    INSTR_STORE = 1'b1
  } instr_type_e;

  typedef struct packed {
    logic                  v;
    instr_type_e           instr_type;
    logic [ROB_PREG_W-1:0] phy_reg;
    logic [ROB_PREG_W-1:0] old_phy;
    logic [ROB_DATA_W-1:0] result;
    logic                  comp;
  } rob_entry_t;

  // Legacy fixed two-slot row, kept for older users of the table.
  typedef struct packed {
    rob_entry_t [1:0] slot;
  } rob_row;

endpackage

// File: rtl/reorder_buffer_retire_sel.sv
// Picks up to W consecutive ready rows starting at head for in-order retire.
module rob_retire_sel #(
  parameter  int DEPTH = 16,
  parameter  int W     = 2,
  localparam int IDX_W = $clog2(DEPTH),
  localparam int NW    = $clog2(W + 1)
) (
  input  logic [IDX_W-1:0]        i_head,
  input  logic [DEPTH-1:0]        i_v,
  input  logic [DEPTH-1:0]        i_comp,
  output logic [NW-1:0]           o_n_ret,
  output logic [W-1:0][IDX_W-1:0] o_idx
);

  logic w_run;

  always_comb begin
    o_n_ret = '0;
    w_run   = 1'b1;
    for (int k = 0; k < W; k++) begin
      o_idx[k] = i_head + IDX_W'(k);
      // Scan stops at the first not-ready row to keep retirement in order.
      if (w_run && i_v[o_idx[k]] && i_comp[o_idx[k]])
        o_n_ret = o_n_ret + NW'(1);
      else
        w_run = 1'b0;
    end
  end

endmodule

// File: rtl/reorder_buffer.sv
// Circular reorder buffer: W-wide alloc/retire, C completion ports, flush.
module reorder_buffer
  import reorder_buffer_pkg::*;
#(
  parameter  int DEPTH  = ROB_DEPTH,
  parameter  int W      = ROB_W,
  parameter  int C      = CDB_PORTS,
  parameter  int PREG_W = ROB_PREG_W,
  parameter  int DATA_W = ROB_DATA_W,
  localparam int IDX_W  = $clog2(DEPTH)
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         flush,
  input  logic [W-1:0]                 alloc_valid,
  input  logic [W-1:0]                 alloc_is_store,
  input  logic [W-1:0][PREG_W-1:0]     alloc_pd,
  input  logic [W-1:0][PREG_W-1:0]     alloc_old_pd,
  output logic                         alloc_ready,
  output logic [W-1:0][IDX_W-1:0]      alloc_idx,
  input  logic [C-1:0]                 cmp_valid,
  input  logic [C-1:0][IDX_W-1:0]      cmp_idx,
  input  logic [C-1:0][DATA_W-1:0]     cmp_result,
  output logic [W-1:0]                 ret_valid,
  output logic [W-1:0]                 ret_is_store,
  output logic [W-1:0][PREG_W-1:0]     ret_pd,
  output logic [W-1:0][PREG_W-1:0]     ret_old_pd,
  output logic [W-1:0][DATA_W-1:0]     ret_result,
  output logic [IDX_W:0]               count,
  output logic                         empty,
  output logic                         full
);

  localparam int CNT_W = IDX_W + 1;
  localparam int NW    = $clog2(W + 1);

  rob_entry_t              r_rob [DEPTH];
  logic [IDX_W-1:0]        r_head;
  logic [IDX_W-1:0]        r_tail;
  logic [CNT_W-1:0]        r_count;

  logic [DEPTH-1:0]        w_v;
  logic [DEPTH-1:0]        w_comp;
  logic [NW-1:0]           w_n_ret;
  logic [W-1:0][IDX_W-1:0] w_ret_idx;
  logic [NW-1:0]           w_n_valid;
  logic [NW-1:0]           w_n_acc;

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      w_v[i]    = r_rob[i].v;
      w_comp[i] = r_rob[i].comp;
    end
  end

  rob_retire_sel #(.DEPTH(DEPTH), .W(W)) u_retire_sel (
    .i_head  (r_head),
    .i_v     (w_v),
    .i_comp  (w_comp),
    .o_n_ret (w_n_ret),
    .o_idx   (w_ret_idx)
  );

  // Space check ignores same-cycle retirement to keep the ready path short.
  assign alloc_ready = (CNT_W'(DEPTH) - r_count) >= CNT_W'(W);
  assign count       = r_count;
  assign empty       = (r_count == '0);
  assign full        = (r_count == CNT_W'(DEPTH));

  // Compact valid lanes; an idle lane shows the row the next valid lane gets.
  always_comb begin
    w_n_valid = '0;
    for (int k = 0; k < W; k++) begin
      alloc_idx[k] = r_tail + IDX_W'(w_n_valid);
      if (alloc_valid[k]) w_n_valid = w_n_valid + NW'(1);
    end
    w_n_acc = alloc_ready ? w_n_valid : '0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_rob[i].v    <= 1'b0;
        r_rob[i].comp <= 1'b0;
      end
      r_head       <= '0;
      r_tail       <= '0;
      r_count      <= '0;
      ret_valid    <= '0;
      ret_is_store <= '0;
      ret_pd       <= '0;
      ret_old_pd   <= '0;
      ret_result   <= '0;
    end else if (flush) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_rob[i].v    <= 1'b0;
        r_rob[i].comp <= 1'b0;
      end
      r_head    <= '0;
      r_tail    <= '0;
      r_count   <= '0;
      ret_valid <= '0;
    end else begin
      // Later ports overwrite earlier ones on a shared row.
      for (int c = 0; c < C; c++) begin
        if (cmp_valid[c] && r_rob[cmp_idx[c]].v) begin
          r_rob[cmp_idx[c]].result <= ROB_DATA_W'(cmp_result[c]);
          r_rob[cmp_idx[c]].comp   <= 1'b1;
        end
      end
      for (int k = 0; k < W; k++) begin
        ret_valid[k] <= (NW'(k) < w_n_ret);
        if (NW'(k) < w_n_ret) begin
          ret_is_store[k]            <= (r_rob[w_ret_idx[k]].instr_type == INSTR_STORE);
          ret_pd[k]                  <= PREG_W'(r_rob[w_ret_idx[k]].phy_reg);
          ret_old_pd[k]              <= PREG_W'(r_rob[w_ret_idx[k]].old_phy);
          ret_result[k]              <= DATA_W'(r_rob[w_ret_idx[k]].result);
          r_rob[w_ret_idx[k]].v      <= 1'b0;
          r_rob[w_ret_idx[k]].comp   <= 1'b0;
        end
      end
      if (alloc_ready) begin
        for (int k = 0; k < W; k++) begin
          if (alloc_valid[k]) begin
            r_rob[alloc_idx[k]] <= '{
              v:          1'b1,
              instr_type: alloc_is_store[k] ? INSTR_STORE : INSTR_REG,
              phy_reg:    ROB_PREG_W'(alloc_pd[k]),
              old_phy:    ROB_PREG_W'(alloc_old_pd[k]),
              result:     '0,
              comp:       1'b0
            };
          end
        end
      end
      r_tail  <= r_tail + IDX_W'(w_n_acc);
      r_head  <= r_head + IDX_W'(w_n_ret);
      r_count <= r_count + CNT_W'(w_n_acc) - CNT_W'(w_n_ret);
    end
  end

endmodule

// File: tb/tb_reorder_buffer.sv
// Directed bench for reorder_buffer at DEPTH=16, W=2, C=3.
module tb_reorder_buffer;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             flush;
  logic [1:0]       alloc_valid;
  logic [1:0]       alloc_is_store;
  logic [1:0][5:0]  alloc_pd;
  logic [1:0][5:0]  alloc_old_pd;
  logic             alloc_ready;
  logic [1:0][3:0]  alloc_idx;
  logic [2:0]       cmp_valid;
  logic [2:0][3:0]  cmp_idx;
  logic [2:0][31:0] cmp_result;
  logic [1:0]       ret_valid;
  logic [1:0]       ret_is_store;
  logic [1:0][5:0]  ret_pd;
  logic [1:0][5:0]  ret_old_pd;
  logic [1:0][31:0] ret_result;
  logic [4:0]       count;
  logic             empty;
  logic             full;

  int checks = 0;
  int errors = 0;

  reorder_buffer #(.DEPTH(16), .W(2), .C(3), .PREG_W(6), .DATA_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .alloc_valid(alloc_valid), .alloc_is_store(alloc_is_store),
    .alloc_pd(alloc_pd), .alloc_old_pd(alloc_old_pd),
    .alloc_ready(alloc_ready), .alloc_idx(alloc_idx),
    .cmp_valid(cmp_valid), .cmp_idx(cmp_idx), .cmp_result(cmp_result),
    .ret_valid(ret_valid), .ret_is_store(ret_is_store), .ret_pd(ret_pd),
    .ret_old_pd(ret_old_pd), .ret_result(ret_result),
    .count(count), .empty(empty), .full(full)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    flush = 1'b0; alloc_valid = '0; alloc_is_store = '0; alloc_pd = '0;
    alloc_old_pd = '0; cmp_valid = '0; cmp_idx = '0; cmp_result = '0;
  endtask

  task automatic alloc2(input logic [5:0] pd0, input logic [5:0] pd1,
                        input logic [5:0] op0, input logic [5:0] op1);
    alloc_valid = 2'b11;
    alloc_pd[0] = pd0; alloc_pd[1] = pd1;
    alloc_old_pd[0] = op0; alloc_old_pd[1] = op1;
  endtask

  task automatic cmp(input int p, input logic [3:0] idx, input logic [31:0] r);
    cmp_valid[p] = 1'b1; cmp_idx[p] = idx; cmp_result[p] = r;
  endtask

  initial begin
    idle();
    rst_n = 1'b0;
    tick(); tick();
    chk("rst_count", count, 0);
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_ready", alloc_ready, 1);
    chk("rst_ret_valid", ret_valid, 0);

    // Basic path: two rows, complete out of order, retire together
    rst_n = 1'b1;
    alloc2(6'd33, 6'd34, 6'd1, 6'd2);
    alloc_is_store = 2'b10;
    #1;
    chk("basic_alloc_idx", alloc_idx, {4'd1, 4'd0});
    tick(); idle();
    chk("basic_count", count, 2);
    cmp(0, 4'd1, 32'h11);
    tick(); idle();
    chk("basic_no_ret1", ret_valid, 0);
    cmp(0, 4'd0, 32'h10);
    tick(); idle();
    chk("basic_no_same_edge", ret_valid, 0);
    tick();
    chk("basic_ret_valid", ret_valid, 2'b11);
    chk("basic_ret_pd", ret_pd, {6'd34, 6'd33});
    chk("basic_ret_old_pd", ret_old_pd, {6'd2, 6'd1});
    chk("basic_ret_store", ret_is_store, 2'b10);
    chk("basic_ret_result", ret_result, {32'h11, 32'h10});
    chk("basic_empty", empty, 1);

    // Out-of-order completion behind an incomplete head
    flush = 1'b1;
    tick(); idle();
    chk("ooo_flush_count", count, 0);
    alloc2(6'd10, 6'd11, 6'd20, 6'd21); tick();
    alloc2(6'd12, 6'd13, 6'd22, 6'd23); tick(); idle();
    chk("ooo_count4", count, 4);
    cmp(0, 4'd1, 32'hB1); cmp(1, 4'd2, 32'hB2); cmp(2, 4'd3, 32'hB3);
    tick(); idle();
    tick();
    chk("ooo_blocked", ret_valid, 0);
    chk("ooo_count_hold", count, 4);
    cmp(0, 4'd0, 32'hB0);
    tick(); idle();
    chk("ooo_blocked2", ret_valid, 0);
    tick();
    chk("ooo_ret1_valid", ret_valid, 2'b11);
    chk("ooo_ret1_pd", ret_pd, {6'd11, 6'd10});
    chk("ooo_ret1_result", ret_result, {32'hB1, 32'hB0});
    tick();
    chk("ooo_ret2_valid", ret_valid, 2'b11);
    chk("ooo_ret2_pd", ret_pd, {6'd13, 6'd12});
    tick();
    chk("ooo_idle_valid", ret_valid, 0);
    chk("ooo_hold_pd", ret_pd, {6'd13, 6'd12});
    chk("ooo_count0", count, 0);

    // Full and wrap
    flush = 1'b1;
    tick(); idle();
    for (int i = 0; i < 8; i++) begin
      alloc2(6'(2 * i), 6'(2 * i + 1), 6'(16 + 2 * i), 6'(17 + 2 * i));
      tick();
    end
    chk("full_count", count, 16);
    chk("full_flag", full, 1);
    chk("full_ready", alloc_ready, 0);
    alloc2(6'd63, 6'd63, 6'd63, 6'd63);
    cmp(0, 4'd0, 32'hC0); cmp(1, 4'd1, 32'hC1);
    tick();
    chk("full_drop_count", count, 16);
    cmp_valid = '0;
    tick();
    chk("full_ret_valid", ret_valid, 2'b11);
    chk("full_ret_pd", ret_pd, {6'd1, 6'd0});
    chk("full_ret_result", ret_result, {32'hC1, 32'hC0});
    chk("full_count14", count, 14);
    chk("full_ready_again", alloc_ready, 1);
    alloc_valid = 2'b10;
    #1;
    chk("wrap_idx_lane1_only", alloc_idx, {4'd0, 4'd0});
    alloc_valid = 2'b11;
    #1;
    chk("wrap_idx", alloc_idx, {4'd1, 4'd0});
    tick(); idle();
    chk("wrap_count16", count, 16);

    // Port collision and completion to an empty row
    flush = 1'b1;
    tick(); idle();
    alloc2(6'd50, 6'd51, 6'd0, 6'd0); tick();
    alloc2(6'd52, 6'd53, 6'd0, 6'd0); tick();
    alloc2(6'd54, 6'd55, 6'd0, 6'd0); tick(); idle();
    cmp(0, 4'd5, 32'hAAAA); cmp(1, 4'd9, 32'hDEAD); cmp(2, 4'd5, 32'h5555);
    tick(); idle();
    chk("coll_count", count, 6);
    chk("coll_no_ret", ret_valid, 0);
    cmp(0, 4'd0, 32'hD0); cmp(1, 4'd1, 32'hD1); cmp(2, 4'd2, 32'hD2);
    tick(); idle();
    cmp(0, 4'd3, 32'hD3); cmp(1, 4'd4, 32'hD4);
    tick(); idle();
    chk("coll_ret1", ret_result, {32'hD1, 32'hD0});
    tick();
    chk("coll_ret2", ret_result, {32'hD3, 32'hD2});
    tick();
    chk("coll_ret3_valid", ret_valid, 2'b11);
    chk("coll_ret3_result", ret_result, {32'h5555, 32'hD4});
    chk("coll_ret3_pd", ret_pd, {6'd55, 6'd54});
    tick();
    chk("coll_empty_row_ignored", count, 0);

    // Flush beats alloc, complete and a ready head
    alloc2(6'd1, 6'd2, 6'd3, 6'd4); tick(); idle();
    cmp(0, 4'd6, 32'h66); cmp(1, 4'd7, 32'h77); tick(); idle();
    flush = 1'b1;
    alloc2(6'd9, 6'd9, 6'd9, 6'd9);
    cmp(0, 4'd6, 32'h99);
    tick();
    chk("flush_count", count, 0);
    chk("flush_ret_valid", ret_valid, 0);
    chk("flush_empty", empty, 1);
    flush = 1'b0;
    #1;
    chk("flush_ptr_reset", alloc_idx, {4'd1, 4'd0});
    idle();
    tick();
    chk("flush_no_alloc", count, 0);

    // Reset overrides live traffic
    alloc2(6'd5, 6'd6, 6'd7, 6'd8); tick(); idle();
    chk("pre_rst_count", count, 2);
    rst_n = 1'b0;
    alloc2(6'd5, 6'd6, 6'd7, 6'd8);
    tick();
    chk("mid_rst_count", count, 0);
    chk("mid_rst_ret_pd", ret_pd, 0);
    rst_n = 1'b1;
    idle();
    tick();
    chk("post_rst_empty", empty, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
